// File: rtl/arith_logic_pipe.sv
// Joins a/b/op streams and computes one of eight bitwise functions into a DEPTH-entry result FIFO.
// Latency: 1 cycle from acceptance edge to result_valid; 1 token/cycle when DEPTH>=2 and drained.
// Backpressure: input readies depend only on the registered FIFO count, never on result_ready.
// Optional: define ARITH_LOGIC_PIPE_PERF_EN to add the saturating perf_count dequeue counter.
module arith_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data
`ifdef ARITH_LOGIC_PIPE_PERF_EN
    ,
    output logic [31:0]      perf_count
`endif
);

    // Pointer width is forced to at least one bit so DEPTH=1 still has a legal index.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Count must represent 0..DEPTH inclusive.
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_ANDN = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] op_result;
    logic             space;
    logic             fire;
    logic             deq;

    // Wrap at DEPTH-1 rather than at a power of two so any DEPTH works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Space comes from the registered count only, keeping result_ready out of the input readies.
    assign space    = (count_q < FULL_CNT);
    assign a_ready  = space & b_valid & op_valid;
    assign b_ready  = space & a_valid & op_valid;
    assign op_ready = space & a_valid & b_valid;
    assign fire     = a_valid & b_valid & op_valid & space;

    assign result_valid = (count_q != '0);
    assign deq          = result_valid & result_ready;

    // Head entry is masked to zero when empty so stale storage never leaks onto the bus.
    assign result_data  = result_valid ? mem[rd_ptr_q] : '0;

    // Bitwise function select; purely combinational from op_data and operands into the write port.
    always_comb begin
        op_result = '0;
        case (op_e'(op_data))
            OP_AND:  op_result = a_data & b_data;
            OP_OR:   op_result = a_data | b_data;
            OP_XOR:  op_result = a_data ^ b_data;
            OP_ANDN: op_result = a_data & ~b_data;
            OP_NAND: op_result = ~(a_data & b_data);
            OP_NOR:  op_result = ~(a_data | b_data);
            OP_XNOR: op_result = ~(a_data ^ b_data);
            OP_PASS: op_result = a_data;
            default: op_result = '0;
        endcase
    end

    // Result storage needs no reset: entries are only visible while count says they are valid.
    always_ff @(posedge clk) begin
        if (fire) begin
            mem[wr_ptr_q] <= op_result;
        end
    end

    // Pointers and occupancy; a simultaneous enqueue and dequeue moves both pointers and keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fire) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({fire, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ARITH_LOGIC_PIPE_PERF_EN
    logic [31:0] perf_q;

    // Count delivered results, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (deq && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_arith_logic_pipe.sv
module tb_arith_logic_pipe;

    localparam int W = 8;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a_valid, b_valid, op_valid;
    logic         a_ready, b_ready, op_ready;
    logic [W-1:0] a_data, b_data;
    logic [2:0]   op_data;
    logic         result_valid, result_ready;
    logic [W-1:0] result_data;
`ifdef ARITH_LOGIC_PIPE_PERF_EN
    logic [31:0]  perf_count;
`endif

    arith_logic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_data       (b_data),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_data      (op_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data)
`ifdef ARITH_LOGIC_PIPE_PERF_EN
        ,
        .perf_count   (perf_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the function table written directly from the operation list.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return a & ~b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Scoreboard: a queue of pending results; its size stands in for the FIFO occupancy.
    logic [W-1:0] exp_q[$];
    logic [31:0]  perf_model;
    bit           m_fire, m_deq;
    bit           mon_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            perf_model = 32'd0;
            m_fire = 1'b0;
            m_deq = 1'b0;
        end else begin
            m_fire = a_valid && b_valid && op_valid && (exp_q.size() < D);
            m_deq  = (exp_q.size() != 0) && result_ready;
            if (m_deq) begin
                void'(exp_q.pop_front());
                if (perf_model != 32'hFFFF_FFFF) perf_model = perf_model + 32'd1;
            end
            if (m_fire) exp_q.push_back(ref_op(a_data, b_data, op_data));
        end
    end

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("mon_rvld", result_valid, exp_q.size() != 0);
            check("mon_rdat", result_data, (exp_q.size() != 0) ? exp_q[0] : '0);
            check("mon_ardy", a_ready, (exp_q.size() < D) && b_valid && op_valid);
            check("mon_brdy", b_ready, (exp_q.size() < D) && a_valid && op_valid);
            check("mon_ordy", op_ready, (exp_q.size() < D) && a_valid && b_valid);
`ifdef ARITH_LOGIC_PIPE_PERF_EN
            check("mon_perf", perf_count, perf_model);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tok(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        a_valid = v; b_valid = v; op_valid = v;
        a_data = a; b_data = b; op_data = op;
    endtask

    logic [W-1:0] all_exp [8];

    initial begin
        all_exp[0] = 8'h48; all_exp[1] = 8'hDE; all_exp[2] = 8'h96; all_exp[3] = 8'h82;
        all_exp[4] = 8'hB7; all_exp[5] = 8'h21; all_exp[6] = 8'h69; all_exp[7] = 8'hCA;

        rst_n = 1'b0;
        result_ready = 1'b0;
        set_tok(1'b0, '0, '0, 3'd0);
        repeat (2) step();

        // Reset state, including readies following the join equations while held in reset.
        check("rst_rvld", result_valid, 0);
        check("rst_rdat", result_data, 0);
        check("rst_ardy_idle", a_ready, 0);
        a_valid = 1'b1; b_valid = 1'b1; op_valid = 1'b1;
        #1;
        check("rst_ardy", a_ready, 1);
        check("rst_brdy", b_ready, 1);
        check("rst_ordy", op_ready, 1);
        set_tok(1'b0, '0, '0, 3'd0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // Asynchronous reset with two results buffered.
        set_tok(1'b1, 8'h33, 8'h0F, 3'd1);
        step();
        set_tok(1'b1, 8'h44, 8'hF0, 3'd2);
        step();
        set_tok(1'b0, '0, '0, 3'd0);
        check("mrst_full_rvld", result_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_rvld", result_valid, 0);
        check("mrst_rdat", result_data, 0);
        #1 rst_n = 1'b1;
        step();
        check("mrst_after_rvld", result_valid, 0);

        // Every function code with fixed operands, one per cycle.
        result_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_tok(1'b1, 8'hCA, 8'h5C, 3'(k));
            step();
            check($sformatf("op%0d_rvld", k), result_valid, 1);
            check($sformatf("op%0d_rdat", k), result_data, all_exp[k]);
        end
        set_tok(1'b0, '0, '0, 3'd0);
        repeat (2) step();

        // Backpressure: fill, stall, then drain in order.
        result_ready = 1'b0;
        set_tok(1'b1, 8'hF0, 8'h3C, 3'd2);
        step();
        check("bp_first", result_data, 8'hCC);
        set_tok(1'b1, 8'h0F, 8'hFF, 3'd0);
        step();
        set_tok(1'b1, 8'hAA, 8'h55, 3'd1);
        step();
        step();
        check("bp_ardy", a_ready, 0);
        check("bp_brdy", b_ready, 0);
        check("bp_ordy", op_ready, 0);
        check("bp_hold", result_data, 8'hCC);
        result_ready = 1'b1;
        step();
        check("bp_drain1", result_data, 8'h0F);
        step();
        check("bp_drain2", result_data, 8'hFF);
        set_tok(1'b0, '0, '0, 3'd0);
        step();
        check("bp_empty", result_valid, 0);

        // Join hold-off with op missing.
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h12; b_data = 8'h34; op_data = 3'd6;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_ardy", a_ready, 0);
            check("hold_brdy", b_ready, 0);
            check("hold_rvld", result_valid, 0);
        end
        op_valid = 1'b1;
        #1;
        check("hold_go_ardy", a_ready, 1);
        step();
        check("hold_acc_rvld", result_valid, 1);
        check("hold_acc_rdat", result_data, 8'hD9);
        set_tok(1'b0, '0, '0, 3'd0);
        step();

        // Steady enqueue+dequeue at occupancy one, crossing several pointer wraps.
        result_ready = 1'b0;
        set_tok(1'b1, 8'h01, 8'h00, 3'd7);
        step();
        result_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_tok(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
            step();
            check("sim_rdat", result_data, ref_op(a_data, b_data, op_data));
            check("sim_rvld", result_valid, 1);
        end
        set_tok(1'b0, '0, '0, 3'd0);
        repeat (2) step();

`ifdef ARITH_LOGIC_PIPE_PERF_EN
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        check("perf_rst", perf_count, 0);
        for (int i = 0; i < 10; i++) begin
            set_tok(1'b1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
            step();
        end
        set_tok(1'b0, '0, '0, 3'd0);
        repeat (2) step();
        check("perf_ten", perf_count, 10);
        result_ready = 1'b0;
        set_tok(1'b1, 8'h01, 8'h02, 3'd1);
        repeat (2) step();
        force dut.perf_q = 32'hFFFF_FFFE;
        perf_model = 32'hFFFF_FFFE;
        #1 release dut.perf_q;
        result_ready = 1'b1;
        step();
        step();
        set_tok(1'b0, '0, '0, 3'd0);
        repeat (3) step();
        check("perf_sat", perf_count, 32'hFFFF_FFFF);
`endif

        // Random traffic against the scoreboard, with one asynchronous reset in the middle.
        for (int c = 0; c < 1500; c++) begin
            if (m_fire) begin
                a_valid = 1'b0; b_valid = 1'b0; op_valid = 1'b0;
            end
            if (!a_valid && $urandom_range(0, 3) != 0) begin
                a_valid = 1'b1; a_data = W'($urandom);
            end
            if (!b_valid && $urandom_range(0, 3) != 0) begin
                b_valid = 1'b1; b_data = W'($urandom);
            end
            if (!op_valid && $urandom_range(0, 3) != 0) begin
                op_valid = 1'b1; op_data = 3'($urandom_range(0, 7));
            end
            result_ready = ($urandom_range(0, 3) != 0);
            if (c == 700) begin
                #1 rst_n = 1'b0;
                #1;
                check("rnd_rst_rvld", result_valid, 0);
                check("rnd_rst_rdat", result_data, 0);
                #1 rst_n = 1'b1;
            end
            step();
        end
        set_tok(1'b0, '0, '0, 3'd0);
        result_ready = 1'b1;
        repeat (D + 2) step();
        check("final_empty", result_valid, 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arith_logic_pipe.md
# arith_logic_pipe

Registered, operation-selectable bitwise unit for WIDTH-bit operands. It joins the `a`, `b` and `op` valid/ready streams and computes one of eight bitwise functions per token. Results are buffered in a DEPTH-entry output FIFO, so input readiness never depends combinationally on `result_ready`. It sits in the arith datapath wherever a single-function combinational bitwise op would otherwise create a long ready/valid path.

## Interface
- `WIDTH`, 32: operand and result width in bits (≥1).
- `DEPTH`, 2: output FIFO entries (≥1; any integer, not restricted to powers of two).
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_valid`/`a_ready`/`a_data`  in/out/in  1/1/WIDTH  operand A stream.
- `b_valid`/`b_ready`/`b_data`  in/out/in  1/1/WIDTH  operand B stream.
- `op_valid`/`op_ready`/`op_data`  in/out/in  1/1/3  function-select stream.
- `result_valid`/`result_ready`/`result_data`  out/in/out  1/1/WIDTH  result stream.
- `perf_count`  out  32  accepted-result counter; present only with `ARITH_LOGIC_PIPE_PERF_EN`.

## Operation
- Function codes:
  - 0 AND: `a&b`
  - 1 OR: `a|b`
  - 2 XOR: `a^b`
  - 3 ANDN: `a&~b`
  - 4 NAND: `~(a&b)`
  - 5 NOR: `~(a|b)`
  - 6 XNOR: `~(a^b)`
  - 7 PASS: `a`
- Widths: all operations are bitwise and width-preserving; no carries and no sign handling.
- Space signal: `space = (count < DEPTH)`, using the registered count only.
- Readiness:
  - `a_ready = space & b_valid & op_valid`
  - `b_ready = space & a_valid & op_valid`
  - `op_ready = space & a_valid & b_valid`
  - These are independent of `result_ready`.
- Enqueue (`fire`): `a_valid & b_valid & op_valid & space`. On `fire`, the computed word is written at the write pointer.
- Dequeue (`deq`): `result_valid & result_ready`. On `deq`, the read pointer advances.
- FIFO pointers: read and write pointers wrap from DEPTH-1 to 0. `count` ranges over 0..DEPTH.
- Simultaneous `fire` and `deq`: `count` is unchanged and both pointers advance.
  - When `count==DEPTH`, `fire` cannot occur, even if `deq` is asserted that cycle.
- FIFO order: results leave strictly in acceptance order.
- Output drive:
  - `result_valid = (count != 0)`.
  - `result_data` = the head entry when `count != 0`, and all-zeros when empty.
- Output stability: while `result_valid & ~result_ready`, `result_data` is held stable.

## Timing
- Reset (asynchronous assert, synchronous-edge deassert behaviour irrelevant to outputs): `count=0` and both pointers are 0.
  - Reset values: `result_valid=0`, `result_data=0`, `perf_count=0`.
  - `a_ready`, `b_ready` and `op_ready` follow their equations (space=1).
- Reset asserted mid-operation discards all buffered results immediately. No partial token survives.
- Latency: a token accepted at edge N appears with `result_valid=1` after edge N, i.e. 1 cycle.
- Throughput:
  - 1 token/cycle with DEPTH≥2 and `result_ready` held high.
  - With DEPTH=1: 1 token per 2 cycles, because there is no same-cycle refill when full.
- The only combinational paths are:
  - the in-valid → other-in-ready join;
  - `op_data` → datapath → FIFO write data.

## Configuration
- `ARITH_LOGIC_PIPE_PERF_EN` defined:
  - Adds the `perf_count` port and a 32-bit register.
  - The register increments on every `deq`, saturates at 0xFFFFFFFF, and clears on reset.
- Macro undefined: the port and register do not exist. Functional behaviour is otherwise identical.

## Test plan
- Reset mid-burst: fill 2 entries, assert `rst_n=0` asynchronously → `result_valid=0`, `result_data=0` with no clock edge; after release, `count=0`.
- All ops: WIDTH=8, a=0xCA, b=0x5C, ops 0..7 with `result_ready=1` → expect 0x48, 0xDE, 0x96, 0x82, 0xB7, 0x21, 0x69, 0xCA, each one cycle after acceptance.
- Backpressure/full: DEPTH=2, `result_ready=0`, present 3 tokens → first two accepted, then all three readies go to 0. `result_data` holds the first result; release `result_ready` → results drain in order.
- Join hold-off: a and b valid, `op_valid=0` for 5 cycles → no `fire`, `a_ready=b_ready=0`. Assert `op_valid` → accepted on that edge.
- Simultaneous enq/deq: DEPTH=2, count=1, `fire` and `deq` on the same edge → count stays 1 and pointers wrap correctly across ≥4 such cycles.
- With `ARITH_LOGIC_PIPE_PERF_EN`: 10 dequeues → `perf_count=10`. Force the counter to 0xFFFFFFFE and apply 3 dequeues → 0xFFFFFFFF (saturated).
